// File: rtl/iwm_async_if.sv
// CPU-side and drive-side signal bundle for the IWM: the system (CPU decode plus drive models) is master, the controller is slave.
interface iwm_async_if;
    logic        selectIWM;
    logic        _cpuRW;
    logic        _cpuLDS;
    logic [3:0]  cpuAddrRegHi;
    logic [7:0]  dataIn;
    logic [15:0] dataOut;
    logic [2:0]  ca;
    logic        lstrb;
    logic [1:0]  drvEnable;
    logic        drvSelExt;
    logic [15:0] rdByte;
    logic [1:0]  rdStrobe;
    logic [1:0]  sense;
    logic [1:0]  advanceDrive;
    logic [7:0]  wrByte;
    logic [1:0]  wrStrobe;
    logic        writeActive;

    modport master (
        output selectIWM, _cpuRW, _cpuLDS, cpuAddrRegHi, dataIn, rdByte, rdStrobe, sense,
        input  dataOut, ca, lstrb, drvEnable, drvSelExt, advanceDrive, wrByte, wrStrobe, writeActive
    );
    modport slave (
        input  selectIWM, _cpuRW, _cpuLDS, cpuAddrRegHi, dataIn, rdByte, rdStrobe, sense,
        output dataOut, ca, lstrb, drvEnable, drvSelExt, advanceDrive, wrByte, wrStrobe, writeActive
    );
endinterface

// File: rtl/iwm_async.sv
// IWM floppy controller: register bits, read latch with timed clear, byte-timed write path, motor-off hold.
// Register bits visible 1 cycle after access, reads combinational; no backpressure, drives are paced by BYTE_CYCLES.
module iwm_async #(
    parameter int LATCH_CLEAR_CYCLES = 14,
    parameter int BYTE_CYCLES        = 128,
    parameter int MOTOR_OFF_CYCLES   = 8000000
) (
    input  logic       clk8,
    input  logic       _reset,
    iwm_async_if.slave bus
);
    localparam int BW = $clog2(BYTE_CYCLES + 1);
    localparam int CW = $clog2(LATCH_CLEAR_CYCLES + 1);
    localparam int MW = $clog2(MOTOR_OFF_CYCLES + 1);
    localparam logic [BW-1:0] BYTE_RELOAD = BW'(BYTE_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LOAD  = CW'(LATCH_CLEAR_CYCLES);
    localparam logic [MW-1:0] MOTOR_LOAD  = MW'(MOTOR_OFF_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_UNDERRUN} wr_state_e;

    wr_state_e            state_q, state_d;
    logic [2:0]           ca_q, ca_d;
    logic                 lstrb_q, lstrb_d, sel_q, sel_d, q6_q, q6_d, q7_q, q7_d;
    logic [1:0]           en_req_q, en_req_d;
    logic [1:0][MW-1:0]   motor_timer_q, motor_timer_d;
    logic [4:0]           mode_q, mode_d;
    logic [7:0]           read_latch_q, read_latch_d, write_buf_q, write_buf_d, wr_byte_q, wr_byte_d;
    logic                 buf_empty_q, buf_empty_d, underrun_q, underrun_d, rd_access_q, rd_access_d;
    logic [BW-1:0]        byte_timer_q, byte_timer_d;
    logic [CW-1:0]        clear_timer_q, clear_timer_d;
    logic [1:0]           advance_q, advance_d, wr_strobe_q, wr_strobe_d, drv_en;
    logic                 access, rd_access, wr_access, write_active;
    logic [7:0]           data_out_lo;

    assign access       = bus.selectIWM & ~bus._cpuLDS;
    assign rd_access    = access & bus._cpuRW;
    assign wr_access    = access & ~bus._cpuRW;
    assign write_active = (state_q == ST_ACTIVE);

    always_comb begin
        ca_d     = ca_q;
        lstrb_d  = lstrb_q;
        en_req_d = en_req_q;
        sel_d    = sel_q;
        q6_d     = q6_q;
        q7_d     = q7_q;
        if (access) begin
            case (bus.cpuAddrRegHi[3:1])
                3'd0: ca_d[0]          = bus.cpuAddrRegHi[0];
                3'd1: ca_d[1]          = bus.cpuAddrRegHi[0];
                3'd2: ca_d[2]          = bus.cpuAddrRegHi[0];
                3'd3: lstrb_d          = bus.cpuAddrRegHi[0];
                3'd4: en_req_d[sel_q]  = bus.cpuAddrRegHi[0];
                3'd5: sel_d            = bus.cpuAddrRegHi[0];
                3'd6: q6_d             = bus.cpuAddrRegHi[0];
                3'd7: q7_d             = bus.cpuAddrRegHi[0];
            endcase
        end
    end

    // A dropped request keeps the motor spinning unless mode[2] asks for an immediate stop.
    always_comb begin
        motor_timer_d = motor_timer_q;
        for (int i = 0; i < 2; i++) begin
            if (en_req_d[i])
                motor_timer_d[i] = '0;
            else if (en_req_q[i] && !mode_q[2])
                motor_timer_d[i] = MOTOR_LOAD;
            else if (motor_timer_q[i] != '0)
                motor_timer_d[i] = motor_timer_q[i] - MW'(1);
        end
    end

    assign drv_en[0] = en_req_q[0] | (motor_timer_q[0] != '0);
    assign drv_en[1] = en_req_q[1] | (motor_timer_q[1] != '0);

    always_comb begin
        data_out_lo = 8'hEF;
        if (rd_access) begin
            case ({q7_d, q6_d})
                2'b00:   data_out_lo = read_latch_q;
                2'b01:   data_out_lo = {bus.sense[sel_d], 1'b0, |drv_en, mode_q};
                2'b10:   data_out_lo = {buf_empty_q, ~underrun_q, 6'b0};
                default: data_out_lo = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_timer_d = byte_timer_q;
        buf_empty_d  = buf_empty_q;
        underrun_d   = underrun_q;
        write_buf_d  = write_buf_q;
        wr_byte_d    = wr_byte_q;
        wr_strobe_d  = '0;
        mode_d       = mode_q;
        if (!q7_q || !drv_en[sel_q]) begin
            state_d      = ST_IDLE;
            byte_timer_d = '0;
            underrun_d   = 1'b0;
            buf_empty_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_ACTIVE;
                    byte_timer_d = BYTE_RELOAD;
                end
                ST_ACTIVE: begin
                    if (byte_timer_q == '0) begin
                        byte_timer_d = BYTE_RELOAD;
                        if (!buf_empty_q) begin
                            wr_byte_d          = write_buf_q;
                            wr_strobe_d[sel_q] = 1'b1;
                            buf_empty_d        = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = ST_UNDERRUN;
                        end
                    end else begin
                        byte_timer_d = byte_timer_q - BW'(1);
                    end
                end
                default: ;
            endcase
        end
        // CPU data written in a transfer cycle lands after the transfer, so the buffer ends up full.
        if (wr_access && q7_d && q6_d) begin
            if (drv_en == 2'b00) begin
                mode_d = bus.dataIn[4:0];
            end else begin
                write_buf_d = bus.dataIn;
                buf_empty_d = 1'b0;
            end
        end
    end

    always_comb begin
        read_latch_d  = read_latch_q;
        clear_timer_d = clear_timer_q;
        advance_d     = '0;
        rd_access_d   = rd_access;
        if (bus.rdStrobe[sel_q] && !write_active) begin
            read_latch_d  = sel_q ? bus.rdByte[15:8] : bus.rdByte[7:0];
            clear_timer_d = mode_q[0] ? '0 : CLEAR_LOAD;
        end else if (rd_access_q && !rd_access && read_latch_q[7]) begin
            clear_timer_d = CLEAR_LOAD;
        end else if (clear_timer_q != '0) begin
            clear_timer_d = clear_timer_q - CW'(1);
            if (clear_timer_q <= CW'(2)) begin
                clear_timer_d    = '0;
                read_latch_d     = 8'h00;
                advance_d[sel_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk8 or negedge _reset) begin
        if (!_reset) begin
            state_q       <= ST_IDLE;
            ca_q          <= '0;
            lstrb_q       <= 1'b0;
            sel_q         <= 1'b0;
            q6_q          <= 1'b0;
            q7_q          <= 1'b0;
            en_req_q      <= '0;
            motor_timer_q <= '0;
            mode_q        <= '0;
            read_latch_q  <= '0;
            write_buf_q   <= '0;
            wr_byte_q     <= '0;
            buf_empty_q   <= 1'b1;
            underrun_q    <= 1'b0;
            rd_access_q   <= 1'b0;
            byte_timer_q  <= '0;
            clear_timer_q <= '0;
            advance_q     <= '0;
            wr_strobe_q   <= '0;
        end else begin
            state_q       <= state_d;
            ca_q          <= ca_d;
            lstrb_q       <= lstrb_d;
            sel_q         <= sel_d;
            q6_q          <= q6_d;
            q7_q          <= q7_d;
            en_req_q      <= en_req_d;
            motor_timer_q <= motor_timer_d;
            mode_q        <= mode_d;
            read_latch_q  <= read_latch_d;
            write_buf_q   <= write_buf_d;
            wr_byte_q     <= wr_byte_d;
            buf_empty_q   <= buf_empty_d;
            underrun_q    <= underrun_d;
            rd_access_q   <= rd_access_d;
            byte_timer_q  <= byte_timer_d;
            clear_timer_q <= clear_timer_d;
            advance_q     <= advance_d;
            wr_strobe_q   <= wr_strobe_d;
        end
    end

    assign bus.dataOut      = {8'hBE, data_out_lo};
    assign bus.ca           = ca_q;
    assign bus.lstrb        = lstrb_q;
    assign bus.drvEnable    = drv_en;
    assign bus.drvSelExt    = sel_q;
    assign bus.advanceDrive = advance_q;
    assign bus.wrByte       = wr_byte_q;
    assign bus.wrStrobe     = wr_strobe_q;
    assign bus.writeActive  = write_active;
endmodule

// File: tb/tb_iwm_async.sv
// Directed bench for iwm_async with short timing parameters; expected values are hand-computed constants.
module tb_iwm_async;
    logic clk8 = 1'b0;
    logic _reset;
    int   checks = 0;
    int   failures = 0;
    logic [15:0] q;
    int   t, n;

    iwm_async_if bus();

    iwm_async #(
        .LATCH_CLEAR_CYCLES(14),
        .BYTE_CYCLES(8),
        .MOTOR_OFF_CYCLES(20)
    ) dut (
        .clk8(clk8),
        ._reset(_reset),
        .bus(bus)
    );

    always #5 clk8 = ~clk8;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.selectIWM    = 1'b0;
        bus._cpuLDS      = 1'b1;
        bus._cpuRW       = 1'b1;
        bus.cpuAddrRegHi = 4'h0;
        bus.dataIn       = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk8);
        #1;
    endtask

    task automatic acc(input logic [2:0] r, input logic v, input logic rw, input logic [7:0] d);
        bus.selectIWM    = 1'b1;
        bus._cpuLDS      = 1'b0;
        bus._cpuRW       = rw;
        bus.cpuAddrRegHi = {r, v};
        bus.dataIn       = d;
        tick();
        idle_bus();
    endtask

    task automatic rd(input logic [2:0] r, input logic v, output logic [15:0] data);
        bus.selectIWM    = 1'b1;
        bus._cpuLDS      = 1'b0;
        bus._cpuRW       = 1'b1;
        bus.cpuAddrRegHi = {r, v};
        @(negedge clk8);
        data = bus.dataOut;
        tick();
        idle_bus();
    endtask

    task automatic strobe0(input logic [7:0] b);
        bus.rdByte   = {8'h00, b};
        bus.rdStrobe = 2'b01;
        tick();
        bus.rdStrobe = 2'b00;
    endtask

    initial begin
        idle_bus();
        bus.rdByte   = 16'h0000;
        bus.rdStrobe = 2'b00;
        bus.sense    = 2'b00;
        _reset       = 1'b0;
        repeat (3) tick();
        check("rst_dataout", bus.dataOut, 16'hBEEF);
        check("rst_outputs", {bus.ca, bus.lstrb, bus.drvEnable, bus.drvSelExt, bus.wrStrobe,
                              bus.writeActive, bus.advanceDrive, bus.wrByte}, 0);
        _reset = 1'b1;
        tick();

        rd(3'd6, 1'b0, q);  check("read_latch_idle", q, 16'hBE00);
        rd(3'd7, 1'b1, q);  check("handshake_rst", q, 16'hBEC0);
        rd(3'd7, 1'b0, q);

        acc(3'd0, 1'b1, 1'b1, 8'h00);
        acc(3'd2, 1'b1, 1'b1, 8'h00);
        acc(3'd3, 1'b1, 1'b1, 8'h00);
        check("ca_lstrb", {bus.ca, bus.lstrb}, 4'b1011);
        acc(3'd5, 1'b1, 1'b1, 8'h00);
        check("sel_ext", bus.drvSelExt, 1'b1);
        acc(3'd5, 1'b0, 1'b1, 8'h00);
        acc(3'd0, 1'b0, 1'b1, 8'h00);
        acc(3'd2, 1'b0, 1'b1, 8'h00);
        acc(3'd3, 1'b0, 1'b1, 8'h00);
        check("ca_cleared", {bus.ca, bus.lstrb, bus.drvSelExt}, 5'b0);

        // mode register
        acc(3'd6, 1'b1, 1'b1, 8'h00);
        acc(3'd7, 1'b1, 1'b0, 8'h1F);
        rd(3'd7, 1'b0, q);  check("mode_1f", q, 16'hBE1F);
        acc(3'd4, 1'b1, 1'b1, 8'h00);
        acc(3'd7, 1'b1, 1'b0, 8'h00);
        bus.sense = 2'b01;
        rd(3'd7, 1'b0, q);  check("mode_kept_enabled", q, 16'hBEBF);
        bus.sense = 2'b00;
        acc(3'd4, 1'b0, 1'b1, 8'h00);
        check("motor_off_immediate_1f", bus.drvEnable, 2'b00);

        // read latch with timed clear
        strobe0(8'h96);
        rd(3'd6, 1'b0, q);  check("latch_96", q, 16'hBE96);
        tick();
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.advanceDrive[0] && n == 0) n = i;
        end
        check("advance_delay", n, 13);
        rd(3'd6, 1'b0, q);  check("latch_cleared", q, 16'hBE00);

        strobe0(8'h96);
        rd(3'd6, 1'b0, q);
        tick();
        repeat (12) tick();
        bus.rdByte   = 16'h00A5;
        bus.rdStrobe = 2'b01;
        tick();
        bus.rdStrobe = 2'b00;
        check("strobe_beats_clear_adv", bus.advanceDrive, 2'b00);
        rd(3'd6, 1'b0, q);  check("strobe_beats_clear_val", q, 16'hBEA5);
        repeat (20) tick();

        // motor-off hold with mode 00
        acc(3'd6, 1'b1, 1'b1, 8'h00);
        acc(3'd7, 1'b1, 1'b0, 8'h00);
        acc(3'd7, 1'b0, 1'b1, 8'h00);
        acc(3'd4, 1'b1, 1'b1, 8'h00);
        check("motor_on", bus.drvEnable, 2'b01);
        acc(3'd4, 1'b0, 1'b1, 8'h00);
        n = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.drvEnable[0]) n++;
            tick();
        end
        check("motor_hold_cycles", n, 20);
        check("motor_dropped", bus.drvEnable, 2'b00);

        acc(3'd4, 1'b1, 1'b1, 8'h00);
        acc(3'd4, 1'b0, 1'b1, 8'h00);
        repeat (9) tick();
        acc(3'd4, 1'b1, 1'b1, 8'h00);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (!bus.drvEnable[0]) n++;
            tick();
        end
        check("motor_reenable", n, 0);
        acc(3'd4, 1'b0, 1'b1, 8'h00);
        repeat (22) tick();
        check("motor_dropped2", bus.drvEnable, 2'b00);

        acc(3'd6, 1'b1, 1'b1, 8'h00);
        acc(3'd7, 1'b1, 1'b0, 8'h04);
        rd(3'd7, 1'b0, q);  check("mode_04", q, 16'hBE04);
        acc(3'd4, 1'b1, 1'b1, 8'h00);
        check("motor_on_04", bus.drvEnable, 2'b01);
        acc(3'd4, 1'b0, 1'b1, 8'h00);
        check("motor_off_immediate_04", bus.drvEnable, 2'b00);

        // write path
        acc(3'd4, 1'b1, 1'b1, 8'h00);
        acc(3'd6, 1'b1, 1'b1, 8'h00);
        acc(3'd7, 1'b1, 1'b0, 8'hD5);
        t = 0;
        while (!bus.writeActive && t < 10) begin tick(); t++; end
        check("active_entry", t, 1);
        t = 0;
        while (!bus.wrStrobe[0] && t < 20) begin tick(); t++; end
        check("first_strobe_delay", t, 8);
        check("wr_byte", bus.wrByte, 8'hD5);
        rd(3'd6, 1'b0, q);  check("handshake_c0", q, 16'hBEC0);
        check("strobe_one_cycle", bus.wrStrobe, 2'b00);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.wrStrobe != 2'b00) n++;
        end
        check("no_strobe_underrun", n, 0);
        check("underrun_inactive", bus.writeActive, 1'b0);
        rd(3'd7, 1'b1, q);  check("handshake_80", q, 16'hBE80);

        // reset in the middle of a write
        acc(3'd7, 1'b0, 1'b1, 8'h00);
        acc(3'd6, 1'b1, 1'b1, 8'h00);
        acc(3'd7, 1'b1, 1'b0, 8'hA5);
        tick();
        check("active_again", bus.writeActive, 1'b1);
        repeat (3) tick();
        #2 _reset = 1'b0;
        #1;
        check("reset_abort", {bus.writeActive, bus.wrStrobe}, 3'b000);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.wrStrobe != 2'b00) n++;
        end
        check("reset_no_strobe", n, 0);
        _reset = 1'b1;
        tick();
        check("reset_dataout", bus.dataOut, 16'hBEEF);
        rd(3'd7, 1'b1, q);  check("reset_bufempty", q, 16'hBEC0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iwm_async.md
# iwm_async

Next-generation IWM floppy controller for the plus_too core, mapped at $DFE1FF-$DFFFFF. It adds three things:
- a real asynchronous write path with buffer-empty/underrun handshake;
- the mode-register motor-off delay;
- an optional read-latch timeout, with all timing parametrised.

It sits between the 68000 bus decode / VIA SEL line and two byte-level drive models, internal = 0 and external = 1.

## Interface
- LATCH_CLEAR_CYCLES, 14: clk8 cycles from end of a valid data read (or from latch, in L=0 mode) to latch clear.
- BYTE_CYCLES, 128: clk8 cycles per byte on the write path (8 bits × 2 µs).
- MOTOR_OFF_CYCLES, 8000000: enable hold-off when mode M=0 (about 1 s).
- clk8  in  1  8 MHz system clock.
- _reset  in  1  asynchronous, active-low reset.
- selectIWM  in  1  IWM address decode.
- _cpuRW  in  1  1 = read, 0 = write.
- _cpuLDS  in  1  low data strobe, active low.
- cpuAddrRegHi  in  4  A12..A9: register bit select [3:1], value [0].
- dataIn  in  8  CPU write data (low byte).
- dataOut  out  16  {8'hBE, dataOutLo}; dataOutLo = 8'hEF when not reading.
- ca  out  3  {ca2, ca1, ca0} phase lines to drives.
- lstrb  out  1  phase 3 / LSTRB.
- drvEnable  out  2  effective per-drive enable, including motor-off hold.
- drvSelExt  out  1  selected drive.
- rdByte  in  16  drive read bytes, {ext[7:0], int[7:0]}.
- rdStrobe  in  2  one-cycle pulse: new byte valid on rdByte lane.
- sense  in  2  per-drive sense line.
- advanceDrive  out  2  one-cycle pulse to the selected drive when its latch clears.
- wrByte  out  8  byte handed to the selected drive.
- wrStrobe  out  2  one-cycle pulse to the selected drive with wrByte.
- writeActive  out  1  write mode in progress.

## Operation
**Access**
- access = selectIWM & ~_cpuLDS.
- While access is asserted, register bit cpuAddrRegHi[3:1] takes value cpuAddrRegHi[0] every cycle:
  - 0-2 → ca0-ca2; 3 → lstrb;
  - 4 → enable request of the currently selected drive;
  - 5 → drvSelExt; 6 → q6; 7 → q7.
- The "next" values are combinational, registered on clk8.

**Read mux** (access & _cpuRW), selected by {q7Next, q6Next}:
- 00: readLatch.
- 01: {sense[selNext], 0, |drvEnable, mode[4:0]}.
- 10: {bufEmpty, ~underrun, 6'b0}.
- 11: 8'h00.

**CPU write** with {q7Next, q6Next} = 11:
- If |drvEnable = 0: mode ← dataIn[4:0].
- Otherwise: writeBuf ← dataIn and bufEmpty ← 0.

**Motor-off**
- Deasserting an enable request with mode[2] = 0 holds drvEnable for MOTOR_OFF_CYCLES, then drops it.
- Re-request during the hold cancels the timer and keeps the drive enabled.
- With mode[2] = 1, the drop is immediate.

**Write FSM**, states IDLE → ACTIVE → UNDERRUN:
- IDLE → ACTIVE when q7 = 1 and drvEnable[sel] = 1.
  - On entry, byteTimer loads BYTE_CYCLES-1.
- ACTIVE: at byteTimer = 0, the FSM reloads the timer.
  - If bufEmpty = 0: wrByte ← writeBuf, pulse wrStrobe[sel], bufEmpty ← 1.
  - Otherwise: underrun ← 1 and go to UNDERRUN (no further strobes).
- Any state → IDLE when q7 = 0 or drvEnable[sel] = 0. Underrun clears and bufEmpty ← 1.
- writeActive = (state = ACTIVE).

**Read latch**
- rdStrobe[sel] loads readLatch ← rdByte lane.
- A valid read is a falling edge of (access & _cpuRW) with readLatch[7] = 1. It starts clearTimer = LATCH_CLEAR_CYCLES.
- When mode[0] = 0, a latch event also starts clearTimer.
- When clearTimer reaches 1: readLatch ← 0 and pulse advanceDrive[sel].
- Priority: rdStrobe wins over clear. A restart reloads the timer.
- rdStrobe is ignored while writeActive.

## Timing
- Reset values:
  - ca = 0, lstrb = 0, drvEnable = 0, drvSelExt = 0, q6 = q7 = 0;
  - mode = 0, readLatch = 0, bufEmpty = 1, underrun = 0, state IDLE;
  - all timers 0, strobes 0, wrByte = 0, dataOut = 16'hBEEF.
- Register bits are visible on outputs 1 cycle after access. Read data reflects next values in the same cycle.
- First wrStrobe occurs BYTE_CYCLES cycles after entry to ACTIVE, then every BYTE_CYCLES cycles.
- A CPU write in the same cycle as a transfer lands in the buffer after the transfer, so bufEmpty = 0 afterwards.
- Asserting _reset mid-write aborts immediately: no strobe, state IDLE.
- Switching drvSelExt during ACTIVE returns the FSM to IDLE, because drvEnable[sel] is evaluated per cycle.
- readLatch clears exactly LATCH_CLEAR_CYCLES-1 cycles after timer start.

## Test plan
- Reset, then read with q7 = q6 = 0 → dataOut = 16'hBE00; outputs idle, bufEmpty = 1.
- Mode write: q6 = q7 = 1, no drive enabled, write 8'h1F → status read = 8'h1F with sense = 0; a mode write while enabled leaves mode unchanged.
- Write path with BYTE_CYCLES = 8: enable internal drive, set q6 = q7 = 1, write 8'hD5 → wrStrobe[0] 8 cycles after entry with wrByte = 8'hD5, handshake reads 8'hC0. No second byte written → handshake reads 8'h80 (underrun), and no further strobes.
- Read latch: rdStrobe[0] with 8'h96, read it, then release access → readLatch = 0 and advanceDrive[0] pulses 13 cycles later. A rdStrobe arriving on the same cycle as the clear wins.
- Motor-off with mode = 8'h00 and MOTOR_OFF_CYCLES = 20: turn drive off → drvEnable[0] stays 1 for 20 cycles, then 0. Re-enable at cycle 10 → stays 1. With mode = 8'h04 → drops next cycle.
- Reset asserted during ACTIVE → immediate IDLE, no wrStrobe, bufEmpty = 1.
